// File: rtl/tt_pkg.sv
// Shared types for the time-sync receiver: FSM encoding, default RX RAM word indices
// and the magnitude helper used by the lock and slew logic.
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_APPLY   = 2'd3
  } tt_state_e;

  localparam logic [8:0] TS_IDX_DEF  = 9'd3;
  localparam logic [8:0] SEQ_IDX_DEF = 9'd4;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/tt_sync_rx_if.sv
// RX RAM write-stream snoop bus: frame delimiters plus the RAM write strobe/address/data.
interface tt_sync_rx_if;

  logic        rx_frame_start;
  logic        rx_wr_valid;
  logic [8:0]  rx_wr_addr;
  logic [31:0] rx_wr_data;
  logic        rx_frame_done;

  modport master (
    output rx_frame_start, rx_wr_valid, rx_wr_addr, rx_wr_data, rx_frame_done
  );

  modport slave (
    input rx_frame_start, rx_wr_valid, rx_wr_addr, rx_wr_data, rx_frame_done
  );

endinterface

// File: rtl/tt_lock_monitor.sv
// Lock tracker: counts consecutive in-tolerance syncs and drops lock after a silence
// period with no accepted sync.
module tt_lock_monitor
  import tt_pkg::*;
#(
  parameter logic [31:0] LOCK_TOL = 32'd8,
  parameter logic [3:0]  LOCK_CNT = 4'd4,
  parameter logic [31:0] TIMEOUT  = 32'd125000000
) (
  input  logic        e_rxc,
  input  logic        reset,
  input  logic        sync_fire,
  input  logic [31:0] offset,
  output logic        sync_locked
);

  logic [3:0]  tol_cnt_q, tol_cnt_d;
  logic [31:0] silence_q, silence_d;
  logic        locked_q, locked_d;

  always_comb begin
    tol_cnt_d = tol_cnt_q;
    silence_d = silence_q;
    locked_d  = locked_q;
    if (sync_fire) begin
      silence_d = '0;
      if (abs32(offset) <= LOCK_TOL) begin
        if (tol_cnt_q < LOCK_CNT) tol_cnt_d = tol_cnt_q + 4'd1;
        if (tol_cnt_d >= LOCK_CNT) locked_d = 1'b1;
      end else begin
        tol_cnt_d = '0;
        locked_d  = 1'b0;
      end
    end else if (silence_q != TIMEOUT) begin
      // Silence timer saturates at TIMEOUT; the clear fires once on arrival.
      silence_d = silence_q + 32'd1;
      if (silence_d == TIMEOUT) begin
        locked_d  = 1'b0;
        tol_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge e_rxc) begin
    if (reset) begin
      tol_cnt_q <= '0;
      silence_q <= '0;
      locked_q  <= 1'b0;
    end else begin
      tol_cnt_q <= tol_cnt_d;
      silence_q <= silence_d;
      locked_q  <= locked_d;
    end
  end

  assign sync_locked = locked_q;

endmodule

// File: rtl/tt_sync_rx.sv
// Time-sync consumer: snoops RX RAM writes for peer timestamp/sequence, validates each
// frame and steps the local time counter. Define SYNC_SLEW_EN to slew small offsets.
module tt_sync_rx
  import tt_pkg::*;
#(
  parameter logic [8:0]  TS_IDX     = TS_IDX_DEF,
  parameter logic [8:0]  SEQ_IDX    = SEQ_IDX_DEF,
  parameter logic [31:0] LINK_DELAY = 32'd0,
  parameter logic [31:0] LOCK_TOL   = 32'd8,
  parameter logic [3:0]  LOCK_CNT   = 4'd4,
  parameter logic [31:0] TIMEOUT    = 32'd125000000,
  parameter logic [31:0] SLEW_MAX   = 32'd64
) (
  input  logic         e_rxc,
  input  logic         reset,
  tt_sync_rx_if.slave  rx,
  output logic [31:0]  local_time,
  output logic [31:0]  sync_seq,
  output logic [31:0]  sync_offset,
  output logic         sync_valid,
  output logic         sync_locked,
  output logic [15:0]  drop_count
);

  tt_state_e   state_q, state_d;
  logic        ts_ok_q, ts_ok_d, seq_ok_q, seq_ok_d, last_valid_q, last_valid_d;
  logic [31:0] peer_ts_q, peer_ts_d, peer_seq_q, peer_seq_d, elapsed_q, elapsed_d;
  logic [31:0] local_time_q, local_time_d, sync_seq_q, sync_seq_d;
  logic [31:0] sync_offset_q, sync_offset_d;
  logic        sync_valid_q, sync_valid_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic [31:0] target, offset_calc;
  logic        apply_fire;
`ifdef SYNC_SLEW_EN
  logic signed [31:0] resid_q, resid_d;
`endif

  assign target      = peer_ts_q + LINK_DELAY + elapsed_q;
  assign offset_calc = target - (local_time_q + 32'd1);
  assign apply_fire  = (state_q == ST_APPLY);

  always_comb begin
    state_d       = state_q;
    ts_ok_d       = ts_ok_q;
    seq_ok_d      = seq_ok_q;
    last_valid_d  = last_valid_q;
    peer_ts_d     = peer_ts_q;
    peer_seq_d    = peer_seq_q;
    elapsed_d     = elapsed_q;
    sync_seq_d    = sync_seq_q;
    sync_offset_d = sync_offset_q;
    drop_count_d  = drop_count_q;
    sync_valid_d  = 1'b0;
    local_time_d  = local_time_q + 32'd1;
`ifdef SYNC_SLEW_EN
    resid_d = resid_q;
    if (resid_q > 0) begin
      local_time_d = local_time_q + 32'd2;
      resid_d      = resid_q - 32'sd1;
    end else if (resid_q < 0) begin
      local_time_d = local_time_q;
      resid_d      = resid_q + 32'sd1;
    end
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx.rx_frame_start) begin
          state_d  = ST_CAPTURE;
          ts_ok_d  = 1'b0;
          seq_ok_d = 1'b0;
        end
      end
      ST_CAPTURE: begin
        // elapsed freezes on the done cycle so it counts cycles from TS write to done.
        if (rx.rx_frame_start) begin
          ts_ok_d  = 1'b0;
          seq_ok_d = 1'b0;
        end else if (ts_ok_q && !rx.rx_frame_done) begin
          elapsed_d = elapsed_q + 32'd1;
        end
        if (rx.rx_wr_valid && rx.rx_wr_addr == TS_IDX) begin
          peer_ts_d = rx.rx_wr_data;
          ts_ok_d   = 1'b1;
          elapsed_d = 32'd1;
        end
        if (rx.rx_wr_valid && rx.rx_wr_addr == SEQ_IDX) begin
          peer_seq_d = rx.rx_wr_data;
          seq_ok_d   = 1'b1;
        end
        if (rx.rx_frame_done && !rx.rx_frame_start) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (!ts_ok_q || !seq_ok_q || (last_valid_q && peer_seq_q == sync_seq_q)) begin
          if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        sync_offset_d = offset_calc;
        sync_seq_d    = peer_seq_q;
        last_valid_d  = 1'b1;
        sync_valid_d  = 1'b1;
        state_d       = ST_IDLE;
`ifdef SYNC_SLEW_EN
        if (abs32(offset_calc) <= SLEW_MAX) begin
          local_time_d = local_time_q + 32'd1;
          resid_d      = $signed(offset_calc);
        end else begin
          local_time_d = target;
          resid_d      = '0;
        end
`else
        local_time_d = target;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge e_rxc) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ts_ok_q       <= 1'b0;
      seq_ok_q      <= 1'b0;
      last_valid_q  <= 1'b0;
      peer_ts_q     <= '0;
      peer_seq_q    <= '0;
      elapsed_q     <= '0;
      local_time_q  <= '0;
      sync_seq_q    <= '0;
      sync_offset_q <= '0;
      sync_valid_q  <= 1'b0;
      drop_count_q  <= '0;
`ifdef SYNC_SLEW_EN
      resid_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ts_ok_q       <= ts_ok_d;
      seq_ok_q      <= seq_ok_d;
      last_valid_q  <= last_valid_d;
      peer_ts_q     <= peer_ts_d;
      peer_seq_q    <= peer_seq_d;
      elapsed_q     <= elapsed_d;
      local_time_q  <= local_time_d;
      sync_seq_q    <= sync_seq_d;
      sync_offset_q <= sync_offset_d;
      sync_valid_q  <= sync_valid_d;
      drop_count_q  <= drop_count_d;
`ifdef SYNC_SLEW_EN
      resid_q       <= resid_d;
`endif
    end
  end

  tt_lock_monitor #(
    .LOCK_TOL (LOCK_TOL),
    .LOCK_CNT (LOCK_CNT),
    .TIMEOUT  (TIMEOUT)
  ) u_lock (
    .e_rxc       (e_rxc),
    .reset       (reset),
    .sync_fire   (apply_fire),
    .offset      (offset_calc),
    .sync_locked (sync_locked)
  );

  assign local_time  = local_time_q;
  assign sync_seq    = sync_seq_q;
  assign sync_offset = sync_offset_q;
  assign sync_valid  = sync_valid_q;
  assign drop_count  = drop_count_q;

endmodule
